// File: rtl/mux_16_to_1_if.sv
// Bundle of the lane bus, select index, capture enable and selector outputs.
// The testbench drives through master; the selector itself uses slave.
interface mux_16_to_1_if #(
    parameter int DATA_W = 1
);
    logic [16*DATA_W-1:0] in;
    logic [3:0]           sel;
    logic                 en;
    logic [DATA_W-1:0]    out;
    logic                 out_valid;
    logic [15:0]          sel_onehot;

    modport master (
        output in,
        output sel,
        output en,
        input  out,
        input  out_valid,
        input  sel_onehot
    );

    modport slave (
        input  in,
        input  sel,
        input  en,
        output out,
        output out_valid,
        output sel_onehot
    );
endinterface

// File: rtl/mux_16_to_1.sv
// 16-to-1 lane selector with optional output register and a one-hot debug
// decode of the select index.
module mux_16_to_1 #(
    parameter int DATA_W  = 1,
    parameter bit OUT_REG = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mux_16_to_1_if.slave  bus
);

    logic [DATA_W-1:0] lane_sel;
    logic [15:0]       onehot;

    always_comb begin
        lane_sel = bus.in[bus.sel*DATA_W +: DATA_W];
    end

    always_comb begin
        onehot          = 16'h0000;
        onehot[bus.sel] = 1'b1;
    end

    assign bus.sel_onehot = onehot;

    generate
        if (OUT_REG) begin : g_reg
            logic [DATA_W-1:0] out_d;
            logic [DATA_W-1:0] out_q;
            logic              valid_d;
            logic              valid_q;

            always_comb begin
                out_d   = out_q;
                valid_d = valid_q;
                if (bus.en) begin
                    out_d   = lane_sel;
                    valid_d = 1'b1;
                end
            end

            // rst dominates en and clears the register without waiting for clk
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    out_q   <= out_d;
                    valid_q <= valid_d;
                end
            end

            assign bus.out       = out_q;
            assign bus.out_valid = valid_q;
        end else begin : g_comb
            assign bus.out       = lane_sel;
            assign bus.out_valid = ~rst;
        end
    endgenerate

endmodule

// File: tb/tb_mux_16_to_1.sv
// Self-checking bench: registered 1-bit instance plus combinational 4-bit
// instance, compared against an arithmetic shift-and-mask reference model.
module tb_mux_16_to_1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux_16_to_1_if #(.DATA_W(1)) bus_r ();
    mux_16_to_1_if #(.DATA_W(4)) bus_c ();

    mux_16_to_1 #(.DATA_W(1), .OUT_REG(1'b1)) u_reg (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    mux_16_to_1 #(.DATA_W(4), .OUT_REG(1'b0)) u_comb (
        .clk (clk),
        .rst (rst),
        .bus (bus_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic exp_out;
    logic exp_valid;

    function automatic logic ref_lane1(input logic [15:0] v, input int s);
        logic [15:0] t;
        t = v >> s;
        return t[0];
    endfunction

    function automatic logic [3:0] ref_lane4(input logic [63:0] v, input int s);
        logic [63:0] t;
        t = (v >> (4 * s)) & 64'hF;
        return t[3:0];
    endfunction

    function automatic logic [15:0] ref_onehot(input int s);
        return 16'(1) << s;
    endfunction

    // Advance one rising edge, update the reference register, settle 1ns
    task automatic step();
        @(posedge clk);
        if (!rst && bus_r.en) begin
            exp_out   = ref_lane1(bus_r.in, int'(bus_r.sel));
            exp_valid = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus_r.in = 16'hFFFF;
        bus_r.sel = 4'h1;
        bus_r.en = 1'b1;
        rst = 1'b1;
        exp_out = 1'b0;
        exp_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus_r.out !== 1'b0 || bus_r.out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_immediate: out=%b valid=%b required out=0 valid=0",
                     bus_r.out, bus_r.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus_r.out !== 1'b0 || bus_r.out_valid !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL reset_hold[%0d]: out=%b valid=%b required out=0 valid=0",
                         i, bus_r.out, bus_r.out_valid);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus_r.out !== 1'b1 || bus_r.out_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_release: out=%b valid=%b required out=1 valid=1",
                     bus_r.out, bus_r.out_valid);
        end
    endtask

    task automatic test_lane_sweep();
        logic [3:0]  sels [4];
        logic        outs [4];
        logic [15:0] ohs  [4];
        sels = '{4'h0, 4'h1, 4'h6, 4'hC};
        outs = '{1'b0, 1'b1, 1'b0, 1'b1};
        ohs  = '{16'h0001, 16'h0002, 16'h0040, 16'h1000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus_r.in = 16'h3F0A;
            bus_r.en = 1'b1;
            bus_r.sel = sels[i];
            #1;
            n_cmp++;
            if (bus_r.sel_onehot !== ohs[i]) begin
                n_err++;
                $display("[TB] FAIL sweep_onehot sel=%h: got %h required %h",
                         sels[i], bus_r.sel_onehot, ohs[i]);
            end
            step();
            n_cmp++;
            if (bus_r.out !== outs[i] || bus_r.out !== exp_out) begin
                n_err++;
                $display("[TB] FAIL sweep_out sel=%h: got %b required %b",
                         sels[i], bus_r.out, outs[i]);
            end
        end
    endtask

    task automatic test_walk();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                bus_r.en = 1'b1;
                bus_r.in = 16'(1) << i;
                bus_r.sel = (pass == 0) ? 4'(i) : 4'((i + 1) & 15);
                step();
                n_cmp++;
                if (bus_r.out !== (pass == 0 ? 1'b1 : 1'b0)) begin
                    n_err++;
                    $display("[TB] FAIL walk pass=%0d bit=%0d: got %b required %b",
                             pass, i, bus_r.out, (pass == 0 ? 1'b1 : 1'b0));
                end
            end
        end
    endtask

    task automatic test_enable_hold();
        @(negedge clk);
        bus_r.in = 16'h3F0A;
        bus_r.sel = 4'h1;
        bus_r.en = 1'b1;
        step();
        n_cmp++;
        if (bus_r.out !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL hold_capture: got %b required 1", bus_r.out);
        end
        @(negedge clk);
        bus_r.en = 1'b0;
        bus_r.sel = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (bus_r.out !== 1'b1 || bus_r.out_valid !== 1'b1) begin
                n_err++;
                $display("[TB] FAIL hold_cycle[%0d]: out=%b valid=%b required out=1 valid=1",
                         i, bus_r.out, bus_r.out_valid);
            end
        end
        @(negedge clk);
        bus_r.en = 1'b1;
        step();
        n_cmp++;
        if (bus_r.out !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL hold_release: got %b required 0", bus_r.out);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus_r.in = 16'h3F0A;
        bus_r.sel = 4'h1;
        bus_r.en = 1'b1;
        step();
        @(negedge clk);
        bus_r.en = 1'b0;
        #2;
        rst = 1'b1;
        exp_out = 1'b0;
        exp_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus_r.out !== 1'b0 || bus_r.out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL async_pulse: out=%b valid=%b required out=0 valid=0",
                     bus_r.out, bus_r.out_valid);
        end
        #1;
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus_r.out !== 1'b0 || bus_r.out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL async_en_low: out=%b valid=%b required out=0 valid=0",
                     bus_r.out, bus_r.out_valid);
        end
        @(negedge clk);
        bus_r.en = 1'b1;
        step();
        n_cmp++;
        if (bus_r.out !== 1'b1 || bus_r.out_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL async_recapture: out=%b valid=%b required out=1 valid=1",
                     bus_r.out, bus_r.out_valid);
        end
    endtask

    task automatic test_comb_variant();
        @(negedge clk);
        bus_c.in = 64'hFEDCBA9876543210;
        bus_c.en = 1'b0;
        bus_c.sel = 4'h5;
        #1;
        n_cmp++;
        if (bus_c.out !== 4'h5 || bus_c.out_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL comb_sel5: out=%h valid=%b required out=5 valid=1",
                     bus_c.out, bus_c.out_valid);
        end
        bus_c.sel = 4'hF;
        #1;
        n_cmp++;
        if (bus_c.out !== 4'hF) begin
            n_err++;
            $display("[TB] FAIL comb_selF: out=%h required F", bus_c.out);
        end
        rst = 1'b1;
        exp_out = 1'b0;
        exp_valid = 1'b0;
        #1;
        n_cmp++;
        if (bus_c.out_valid !== 1'b0 || bus_c.out !== 4'hF) begin
            n_err++;
            $display("[TB] FAIL comb_rst: out=%h valid=%b required out=F valid=0",
                     bus_c.out, bus_c.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus_c.out_valid !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL comb_rst_release: valid=%b required 1", bus_c.out_valid);
        end
    endtask

    task automatic test_random();
        logic [63:0] wide;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            bus_r.in = 16'($urandom);
            bus_r.sel = 4'($urandom_range(0, 15));
            bus_r.en = ($urandom_range(0, 3) != 0);
            wide = {$urandom, $urandom};
            bus_c.in = wide;
            bus_c.sel = 4'($urandom_range(0, 15));
            bus_c.en = 1'($urandom);
            #1;
            n_cmp++;
            if (bus_r.sel_onehot !== ref_onehot(int'(bus_r.sel))) begin
                n_err++;
                $display("[TB] FAIL rand_onehot[%0d]: got %h required %h",
                         i, bus_r.sel_onehot, ref_onehot(int'(bus_r.sel)));
            end
            n_cmp++;
            if (bus_c.out !== ref_lane4(wide, int'(bus_c.sel))) begin
                n_err++;
                $display("[TB] FAIL rand_comb[%0d]: sel=%h got %h required %h",
                         i, bus_c.sel, bus_c.out, ref_lane4(wide, int'(bus_c.sel)));
            end
            step();
            n_cmp++;
            if (bus_r.out !== exp_out || bus_r.out_valid !== exp_valid) begin
                n_err++;
                $display("[TB] FAIL rand_reg[%0d]: out=%b valid=%b required out=%b valid=%b",
                         i, bus_r.out, bus_r.out_valid, exp_out, exp_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_r.in = '0;
        bus_r.sel = '0;
        bus_r.en = 1'b0;
        bus_c.in = '0;
        bus_c.sel = '0;
        bus_c.en = 1'b0;
        exp_out = 1'b0;
        exp_valid = 1'b0;

        test_reset();
        test_lane_sweep();
        test_walk();
        test_enable_hold();
        test_async_reset();
        test_comb_variant();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
